// File: rtl/half_precision_comparator_if.sv
// Operand/result bundle for the binary16 comparator.
// The producer side drives the operand pair and consumes the registered flags.
interface half_precision_comparator_if;
    logic        in_valid;
    logic [15:0] A_16;
    logic [15:0] B_16;
    logic        out_valid;
    logic        equal_to;
    logic        less_than;
    logic        greater_than;
    logic        unordered;

    modport master (
        output in_valid,
        output A_16,
        output B_16,
        input  out_valid,
        input  equal_to,
        input  less_than,
        input  greater_than,
        input  unordered
    );

    modport slave (
        input  in_valid,
        input  A_16,
        input  B_16,
        output out_valid,
        output equal_to,
        output less_than,
        output greater_than,
        output unordered
    );
endinterface

// File: rtl/half_precision_comparator.sv
// Registered IEEE 754 binary16 comparator: one-cycle latency, one result per accepted pair.
// Exactly one of equal/less/greater/unordered is set for every valid result.
module half_precision_comparator (
    input  logic                              clk,
    input  logic                              rst_n,
    half_precision_comparator_if.slave        bus
);

    logic        a_sign;
    logic        b_sign;
    logic [14:0] a_mag;
    logic [14:0] b_mag;
    logic        a_nan;
    logic        b_nan;
    logic        both_zero;
    logic        mag_lt;

    logic        eq_d;
    logic        lt_d;
    logic        gt_d;
    logic        un_d;

    logic        out_valid_q;
    logic        eq_q;
    logic        lt_q;
    logic        gt_q;
    logic        un_q;

    assign a_sign    = bus.A_16[15];
    assign b_sign    = bus.B_16[15];
    assign a_mag     = bus.A_16[14:0];
    assign b_mag     = bus.B_16[14:0];
    assign a_nan     = (&bus.A_16[14:10]) && (|bus.A_16[9:0]);
    assign b_nan     = (&bus.B_16[14:10]) && (|bus.B_16[9:0]);
    assign both_zero = (a_mag == 15'd0) && (b_mag == 15'd0);
    // Sign-magnitude with biased exponent: raw magnitude bits order like the values,
    // including subnormals and infinities.
    assign mag_lt    = (a_mag < b_mag);

    always_comb begin
        eq_d = 1'b0;
        lt_d = 1'b0;
        gt_d = 1'b0;
        un_d = 1'b0;
        if (a_nan || b_nan) begin
            un_d = 1'b1;
        end else if (both_zero || (bus.A_16 == bus.B_16)) begin
            eq_d = 1'b1;
        end else if (a_sign != b_sign) begin
            lt_d = a_sign;
            gt_d = b_sign;
        end else if (!a_sign) begin
            lt_d = mag_lt;
            gt_d = !mag_lt;
        end else begin
            lt_d = !mag_lt;
            gt_d = mag_lt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            gt_q        <= 1'b0;
            un_q        <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                eq_q <= eq_d;
                lt_q <= lt_d;
                gt_q <= gt_d;
                un_q <= un_d;
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.equal_to     = eq_q;
    assign bus.less_than    = lt_q;
    assign bus.greater_than = gt_q;
    assign bus.unordered    = un_q;

endmodule

// File: tb/tb_half_precision_comparator.sv
// Directed-vector bench for the binary16 comparator; flags are packed {eq, lt, gt, un}.
module tb_half_precision_comparator;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    localparam logic [3:0] EQ = 4'b1000;
    localparam logic [3:0] LT = 4'b0100;
    localparam logic [3:0] GT = 4'b0010;
    localparam logic [3:0] UN = 4'b0001;

    half_precision_comparator_if cmp_if ();

    half_precision_comparator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cmp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] observed();
        return {cmp_if.out_valid, cmp_if.equal_to, cmp_if.less_than,
                cmp_if.greater_than, cmp_if.unordered};
    endfunction

    // Present a pair at the falling edge, then advance to just after the sampling edge.
    task automatic drive_pair(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        cmp_if.in_valid = 1'b1;
        cmp_if.A_16     = a;
        cmp_if.B_16     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        cmp_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        drive_pair(16'h4733, 16'h464D);
        got = observed();
        checks++;
        if (got !== {1'b1, GT}) begin
            errors++;
            $display("FAIL reset_pre got %b exp %b", got, {1'b1, GT});
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = observed();
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL reset_async got %b exp %b", got, 5'b0);
        end
        cmp_if.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got = observed();
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", got, 5'b0);
        end
    endtask

    task automatic test_latency();
        logic [4:0] got;
        @(negedge clk);
        cmp_if.in_valid = 1'b1;
        cmp_if.A_16     = 16'h4566;
        cmp_if.B_16     = 16'h4566;
        #1;
        got = observed();
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL latency_before_edge got %b exp %b", got, 5'b0);
        end
        @(posedge clk);
        #1;
        got = observed();
        checks++;
        if (got !== {1'b1, EQ}) begin
            errors++;
            $display("FAIL latency_after_edge got %b exp %b", got, {1'b1, EQ});
        end
    endtask

    task automatic test_compare();
        logic [15:0] va [16];
        logic [15:0] vb [16];
        logic [3:0]  ve [16];
        logic [4:0]  got;
        va[0]  = 16'h4566; vb[0]  = 16'h4566; ve[0]  = EQ;
        va[1]  = 16'hC566; vb[1]  = 16'hC566; ve[1]  = EQ;
        va[2]  = 16'h4733; vb[2]  = 16'h464D; ve[2]  = GT;
        va[3]  = 16'hC64D; vb[3]  = 16'hC733; ve[3]  = GT;
        va[4]  = 16'h440D; vb[4]  = 16'h4880; ve[4]  = LT;
        va[5]  = 16'hC880; vb[5]  = 16'hC40D; ve[5]  = LT;
        va[6]  = 16'hC566; vb[6]  = 16'h4566; ve[6]  = LT;
        va[7]  = 16'h0000; vb[7]  = 16'h8000; ve[7]  = EQ;
        va[8]  = 16'h7C00; vb[8]  = 16'h7C00; ve[8]  = EQ;
        va[9]  = 16'hFC00; vb[9]  = 16'hFBFF; ve[9]  = LT;
        va[10] = 16'h7C00; vb[10] = 16'h7BFF; ve[10] = GT;
        va[11] = 16'h0001; vb[11] = 16'h0000; ve[11] = GT;
        va[12] = 16'h7E00; vb[12] = 16'h3C00; ve[12] = UN;
        va[13] = 16'h7E00; vb[13] = 16'h7E00; ve[13] = UN;
        va[14] = 16'h3C00; vb[14] = 16'hFE01; ve[14] = UN;
        va[15] = 16'h8000; vb[15] = 16'h0001; ve[15] = LT;
        for (int i = 0; i < 16; i++) begin
            drive_pair(va[i], vb[i]);
            got = observed();
            checks++;
            if (got !== {1'b1, ve[i]}) begin
                errors++;
                $display("FAIL compare_%0d %h/%h got %b exp %b",
                         i, va[i], vb[i], got, {1'b1, ve[i]});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [3:0]  ve [3];
        logic [4:0]  got;
        va[0] = 16'h3C00; vb[0] = 16'h4000; ve[0] = LT;
        va[1] = 16'hBC00; vb[1] = 16'hC000; ve[1] = GT;
        va[2] = 16'h8000; vb[2] = 16'h0000; ve[2] = EQ;
        for (int i = 0; i < 3; i++) begin
            drive_pair(va[i], vb[i]);
            got = observed();
            checks++;
            if (got !== {1'b1, ve[i]}) begin
                errors++;
                $display("FAIL stream_%0d got %b exp %b", i, got, {1'b1, ve[i]});
            end
        end
        // Operands change during the gap but must not be captured.
        cmp_if.A_16 = 16'h7E00;
        drive_idle();
        got = observed();
        checks++;
        if (got !== {1'b0, EQ}) begin
            errors++;
            $display("FAIL gap_hold got %b exp %b", got, {1'b0, EQ});
        end
        drive_idle();
        got = observed();
        checks++;
        if (got !== {1'b0, EQ}) begin
            errors++;
            $display("FAIL gap_hold2 got %b exp %b", got, {1'b0, EQ});
        end
        drive_pair(16'h4880, 16'h440D);
        got = observed();
        checks++;
        if (got !== {1'b1, GT}) begin
            errors++;
            $display("FAIL gap_resume got %b exp %b", got, {1'b1, GT});
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        cmp_if.in_valid = 1'b0;
        cmp_if.A_16     = 16'h0000;
        cmp_if.B_16     = 16'h0000;
        #1;
        checks++;
        if (observed() !== 5'b0) begin
            errors++;
            $display("FAIL reset_initial got %b exp %b", observed(), 5'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        test_reset();
        test_latency();
        test_compare();
        test_back_to_back();
        drive_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
